// File: rtl/onchip_mem_avalon_pipelined.sv
// Parametrised single-port Avalon-MM on-chip RAM: pipelined reads, clear engine, range protection.
// Optional per-byte even parity is enabled by defining ONCHIP_MEM_PARITY_EN.
module onchip_mem_avalon_pipelined #(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 76800,
  parameter int ADDR_W         = 17,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                waitrequest,
  input  logic                clear_req,
  output logic                busy,
  output logic                addr_err,
`ifdef ONCHIP_MEM_PARITY_EN
  output logic                parity_err,
`endif
  input  logic                addr_err_clr
);

  localparam int NB = DATA_W / 8;
`ifdef ONCHIP_MEM_PARITY_EN
  localparam int MEM_W = DATA_W + NB;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [MEM_W-1:0] ZERO_W   = {MEM_W{1'b0}};

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_READY = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
  localparam logic   RST_WAIT  = (CLEAR_ON_RESET != 0) ? 1'b1 : 1'b0;

  function automatic logic [MEM_W-1:0] f_encode(input logic [DATA_W-1:0] d);
    logic [MEM_W-1:0] w;
    w = ZERO_W;
    w[DATA_W-1:0] = d;
`ifdef ONCHIP_MEM_PARITY_EN
    for (int i = 0; i < NB; i++) begin
      w[DATA_W+i] = ^d[8*i +: 8];
    end
`endif
    return w;
  endfunction

`ifdef ONCHIP_MEM_PARITY_EN
  function automatic logic f_parity_ok(input logic [MEM_W-1:0] w);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NB; i++) begin
      if ((^w[8*i +: 8]) != w[DATA_W+i]) ok = 1'b0;
    end
    return ok;
  endfunction
`endif

  state_t           r_state;
  logic [IDX_W-1:0] r_clr_ptr;
  logic [MEM_W-1:0] r_mem [DEPTH];
  logic             r_a_v;
  logic [MEM_W-1:0] r_a_d;
  logic             w_in_range;
  logic [IDX_W-1:0] w_idx;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic             w_pending;
  logic             w_out_v;
  logic [MEM_W-1:0] w_out_d;

  // Request decode; a simultaneous write suppresses the read
  always_comb begin
    w_in_range = ({1'b0, address} < DEPTH_L);
    w_idx      = IDX_W'(address);
    w_wr_acc   = chipselect & write & ~waitrequest;
    w_rd_acc   = chipselect & read & ~write & ~waitrequest;
  end

  // Control FSM; waitrequest/busy are registered from the next state only
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= RST_STATE;
      r_clr_ptr   <= {IDX_W{1'b0}};
      waitrequest <= RST_WAIT;
      busy        <= RST_WAIT;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (r_clr_ptr == LAST_IDX) begin
            r_state     <= S_READY;
            r_clr_ptr   <= {IDX_W{1'b0}};
            waitrequest <= 1'b0;
            busy        <= 1'b0;
          end else begin
            r_clr_ptr <= r_clr_ptr + IDX_W'(1);
          end
        end
        S_READY: begin
          if (clear_req) begin
            r_state     <= w_pending ? S_DRAIN : S_CLEAR;
            r_clr_ptr   <= {IDX_W{1'b0}};
            waitrequest <= 1'b1;
            busy        <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (!w_pending) r_state <= S_CLEAR;
        end
        default: begin
          r_state     <= S_CLEAR;
          r_clr_ptr   <= {IDX_W{1'b0}};
          waitrequest <= 1'b1;
          busy        <= 1'b1;
        end
      endcase
    end
  end

  // Storage array: clear engine writes zero words, otherwise byte-lane writes in range
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_clr_ptr] <= f_encode({DATA_W{1'b0}});
    end else if (w_wr_acc && w_in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (byteenable[i]) begin
          r_mem[w_idx][8*i +: 8] <= writedata[8*i +: 8];
`ifdef ONCHIP_MEM_PARITY_EN
          r_mem[w_idx][DATA_W+i] <= ^writedata[8*i +: 8];
`endif
        end
      end
    end
  end

  // First read stage; out-of-range reads return zero but still complete
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_v <= 1'b0;
      r_a_d <= ZERO_W;
    end else begin
      r_a_v <= w_rd_acc;
      if (w_rd_acc) r_a_d <= w_in_range ? r_mem[w_idx] : ZERO_W;
    end
  end

  // Only reads not yet on the output count as outstanding for the drain
  generate
    if (OUT_REG != 0) begin : g_oreg
      logic             r_b_v;
      logic [MEM_W-1:0] r_b_d;
      // Optional output register stage
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_b_v <= 1'b0;
          r_b_d <= ZERO_W;
        end else begin
          r_b_v <= r_a_v;
          if (r_a_v) r_b_d <= r_a_d;
        end
      end
      assign w_out_v   = r_b_v;
      assign w_out_d   = r_b_d;
      assign w_pending = r_a_v;
    end else begin : g_noreg
      assign w_out_v   = r_a_v;
      assign w_out_d   = r_a_d;
      assign w_pending = 1'b0;
    end
  endgenerate

  assign readdata      = w_out_d[DATA_W-1:0];
  assign readdatavalid = w_out_v;

  // Sticky range error; a set in the same cycle as a clear wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_err <= 1'b0;
    end else if ((w_rd_acc | w_wr_acc) & ~w_in_range) begin
      addr_err <= 1'b1;
    end else if (addr_err_clr) begin
      addr_err <= 1'b0;
    end
  end

`ifdef ONCHIP_MEM_PARITY_EN
  // Sticky parity error, checked on every delivered read word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_err <= 1'b0;
    end else if (w_out_v && !f_parity_ok(w_out_d)) begin
      parity_err <= 1'b1;
    end else if (addr_err_clr) begin
      parity_err <= 1'b0;
    end
  end
`endif

endmodule
